z80_regset_seq: RTL and testbench

- Sequenced, parametrised successor to the combinational register-set override for the T80pa DIR interface.
- Captures a byte-streamed Z80 register image from the loader, merges it with live CPU state and PC/SP overrides, then runs a bus-request handshake before pulsing dir_set.
- Sits between the cassette/CMD loader and the T80pa CPU: dir_out/dir_set go to the CPU DIR/DIRSet pins, cpu_busrq goes to BUSRQ_n (inverted at top level).

---
 rtl/z80_regset_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_z80_regset_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_regset_seq.sv
// -----------------------------------------------------------------------------
// z80_regset_seq
//
// Sequenced register-set override for the T80pa DIR interface. It captures a
// byte-streamed Z80 register image from the loader and merges it with the live
// CPU register set and the PC/SP overrides. It then requests the bus and
// pulses dir_set while the merged vector is held on dir_out.
//
// Optional build macro: REGSET_FORCE_IM1_EN
//   When defined, the latched dir_out[211:208] is forced to 4'b0001
//   (IFF2=0, IFF1=0, IM=1). When undefined, those bits follow the merge rule.
//
// Ports
//   clk_sys        in   system clock
//   reset          in   synchronous, active-high reset
//   dir_in[211:0]  in   live T80pa register set (fallback for unloaded bytes)
//   load_start     in   pulse: clear image mask, byte counter and err
//   load_wr        in   image byte strobe (one byte per cycle)
//   load_data[7:0] in   image byte
//   execute_addr   in   start address used as PC when PC_MODE=0
//   execute_enable in   pulse: request register load and jump
//   cpu_busak      in   CPU bus acknowledge, active high
//   cpu_busrq      out  CPU bus request, active high
//   dir_out[211:0] out  register set to CPU (registered)
//   dir_set        out  register write strobe, SET_CYCLES cycles long
//   busy           out  high in REQ/SET/REL
//   err            out  sticky overflow / bus-acknowledge timeout flag
// -----------------------------------------------------------------------------
module z80_regset_seq #(
  parameter logic [15:0] SP_ADDR       = 16'h4200,
  parameter int unsigned PC_MODE       = 0,
  parameter int unsigned SP_MODE       = 0,
  parameter int unsigned SET_CYCLES    = 4,
  parameter int unsigned BUSAK_TIMEOUT = 1024
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic [211:0] dir_in,
  input  logic         load_start,
  input  logic         load_wr,
  input  logic [7:0]   load_data,
  input  logic [15:0]  execute_addr,
  input  logic         execute_enable,
  input  logic         cpu_busak,
  output logic         cpu_busrq,
  output logic [211:0] dir_out,
  output logic         dir_set,
  output logic         busy,
  output logic         err
);

  localparam int unsigned   TO_W     = $clog2(BUSAK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSAK_TIMEOUT);
  localparam logic [7:0]    SET_LAST = 8'(SET_CYCLES - 1);
  localparam logic [4:0]    N_BYTES  = 5'd27;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_REQ  = 3'd2,
    S_SET  = 3'd3,
    S_REL  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [211:0]      img_q, img_d;
  logic [26:0]       mask_q, mask_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [211:0]      dir_out_q, dir_out_d;
  logic              dir_set_q, dir_set_d;
  logic              busrq_q, busrq_d;
  logic              busy_q, busy_d;
  logic [7:0]        set_cnt_q, set_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [211:0]      byte_mrg_s;
  logic [211:0]      latch_s;

  // Per-byte merge: loaded image bytes win, everything else falls back to dir_in.
  always_comb begin
    byte_mrg_s = dir_in;
    for (int k = 0; k < 26; k++) begin
      if (mask_q[k]) begin
        byte_mrg_s[8*k +: 8] = img_q[8*k +: 8];
      end else begin
        byte_mrg_s[8*k +: 8] = dir_in[8*k +: 8];
      end
    end
    // Byte 26 only carries IFF2, IFF1, IM[1:0]
    if (mask_q[26]) begin
      byte_mrg_s[211:208] = img_q[211:208];
    end else begin
      byte_mrg_s[211:208] = dir_in[211:208];
    end
  end

  // Apply PC/SP overrides on top of the byte merge to form the latched vector.
  always_comb begin
    latch_s        = byte_mrg_s;
    latch_s[79:64] = (PC_MODE == 32'd0) ? execute_addr : byte_mrg_s[79:64];
    latch_s[63:48] = (SP_MODE == 32'd0) ? SP_ADDR      : byte_mrg_s[63:48];
`ifdef REGSET_FORCE_IM1_EN
    latch_s[211:208] = 4'b0001;
`endif
  end

  // Next-state and next-output logic for the capture / handshake sequencer.
  always_comb begin
    state_d   = state_q;
    img_d     = img_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    dir_out_d = dir_out_q;
    set_cnt_d = set_cnt_q;
    to_cnt_d  = to_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          mask_d  = 27'd0;
          cnt_d   = 5'd0;
          err_d   = 1'b0;
        end else if (execute_enable) begin
          state_d  = S_REQ;
          to_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        if (load_start) begin
          // Restart the capture from byte 0
          state_d = S_LOAD;
          mask_d  = 27'd0;
          cnt_d   = 5'd0;
          err_d   = 1'b0;
        end else begin
          if (load_wr) begin
            if (cnt_q < N_BYTES) begin
              for (int k = 0; k < 26; k++) begin
                img_d[8*k +: 8] = (cnt_q == 5'(k)) ? load_data : img_q[8*k +: 8];
              end
              img_d[211:208] = (cnt_q == 5'd26) ? load_data[3:0] : img_q[211:208];
              mask_d[cnt_q]  = 1'b1;
              cnt_d          = cnt_q + 5'd1;
            end else begin
              // Image is full: drop the byte, flag it, keep the counter saturated
              err_d = 1'b1;
              cnt_d = cnt_q;
            end
          end else begin
            cnt_d = cnt_q;
          end
          if (execute_enable) begin
            state_d  = S_REQ;
            to_cnt_d = '0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_REQ: begin
        if (cpu_busak) begin
          // execute_addr is sampled here, at latch time
          dir_out_d = latch_s;
          set_cnt_d = 8'd0;
          state_d   = S_SET;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          state_d  = S_REQ;
        end
      end

      S_SET: begin
        if (set_cnt_q == SET_LAST) begin
          state_d = S_REL;
        end else begin
          set_cnt_d = set_cnt_q + 8'd1;
          state_d   = S_SET;
        end
      end

      S_REL: begin
        if (!cpu_busak) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REL;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Request rises one cycle after entering REQ and drops on leaving SET or on timeout
    busrq_d   = ((state_q == S_REQ) || (state_q == S_SET)) &&
                ((state_d == S_REQ) || (state_d == S_SET));
    dir_set_d = (state_d == S_SET);
    busy_d    = (state_d == S_REQ) || (state_d == S_SET) || (state_d == S_REL);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      img_q     <= 212'd0;
      mask_q    <= 27'd0;
      cnt_q     <= 5'd0;
      err_q     <= 1'b0;
      dir_out_q <= 212'd0;
      dir_set_q <= 1'b0;
      busrq_q   <= 1'b0;
      busy_q    <= 1'b0;
      set_cnt_q <= 8'd0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      img_q     <= img_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      dir_out_q <= dir_out_d;
      dir_set_q <= dir_set_d;
      busrq_q   <= busrq_d;
      busy_q    <= busy_d;
      set_cnt_q <= set_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign cpu_busrq = busrq_q;
  assign dir_out   = dir_out_q;
  assign dir_set   = dir_set_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_z80_regset_seq.sv
// -----------------------------------------------------------------------------
// Testbench for z80_regset_seq. Two instances share the loader and reset:
// dut0 uses PC_MODE=0/SP_MODE=0, dut1 uses PC_MODE=1/SP_MODE=1; both use
// SET_CYCLES=4 and BUSAK_TIMEOUT=16. Expected dir_out vectors are queued per
// instance and a monitor compares them when dir_set rises.
// -----------------------------------------------------------------------------
module tb_z80_regset_seq;

  logic         clk_sys = 1'b0;
  logic         reset;
  logic [211:0] dir_in;
  logic         load_start, load_wr;
  logic [7:0]   load_data;
  logic [15:0]  execute_addr;
  logic         exec0, exec1, busak0, busak1;
  logic         busrq0, busrq1, dset0, dset1, busy0, busy1, err0, err1;
  logic [211:0] dout0, dout1;

  int checks = 0;
  int errors = 0;
  logic [211:0] exp_q0[$];
  logic [211:0] exp_q1[$];
  logic [7:0]   img[28];

  always #5 clk_sys = ~clk_sys;

  z80_regset_seq #(.SP_ADDR(16'h4200), .PC_MODE(0), .SP_MODE(0),
                   .SET_CYCLES(4), .BUSAK_TIMEOUT(16)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .dir_in(dir_in),
    .load_start(load_start), .load_wr(load_wr), .load_data(load_data),
    .execute_addr(execute_addr), .execute_enable(exec0), .cpu_busak(busak0),
    .cpu_busrq(busrq0), .dir_out(dout0), .dir_set(dset0), .busy(busy0), .err(err0));

  z80_regset_seq #(.SP_ADDR(16'h4200), .PC_MODE(1), .SP_MODE(1),
                   .SET_CYCLES(4), .BUSAK_TIMEOUT(16)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .dir_in(dir_in),
    .load_start(load_start), .load_wr(load_wr), .load_data(load_data),
    .execute_addr(execute_addr), .execute_enable(exec1), .cpu_busak(busak1),
    .cpu_busrq(busrq1), .dir_out(dout1), .dir_set(dset1), .busy(busy1), .err(err1));

  task automatic chk_v(input string name, input logic [211:0] act, input logic [211:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [211:0] im_fix(input logic [211:0] v);
    logic [211:0] r;
    r = v;
`ifdef REGSET_FORCE_IM1_EN
    r[211:208] = 4'b0001;
`endif
    return r;
  endfunction

  function automatic logic get_busrq(input int w);
    return (w == 0) ? busrq0 : busrq1;
  endfunction

  function automatic logic get_dset(input int w);
    return (w == 0) ? dset0 : dset1;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? busy0 : busy1;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Wait (bounded) on negedges until dir_set of instance w equals lvl
  task automatic wait_dset(input int w, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_sys);
      if (get_dset(w) == lvl) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic load_img(input int n);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_wr   = 1'b1;
      load_data = img[i];
      tick();
    end
    load_wr = 1'b0;
  endtask

  // Full execute handshake on instance w; execute_addr changes to late_addr after the request
  task automatic do_exec(input int w, input logic [15:0] late_addr);
    bit ok;
    if (w == 0) exec0 = 1'b1; else exec1 = 1'b1;
    tick();
    exec0 = 1'b0;
    exec1 = 1'b0;
    execute_addr = late_addr;
    @(negedge clk_sys);
    chk_i($sformatf("busrq_entry_dut%0d", w), 32'(get_busrq(w)), 32'd0);
    tick();
    @(negedge clk_sys);
    chk_i($sformatf("busrq_req_dut%0d", w), 32'(get_busrq(w)), 32'd1);
    tick();
    if (w == 0) busak0 = 1'b1; else busak1 = 1'b1;
    wait_dset(w, 1'b1, ok);
    chk_i($sformatf("dset_rise_in_time_dut%0d", w), 32'(ok), 32'd1);
    wait_dset(w, 1'b0, ok);
    chk_i($sformatf("dset_fall_in_time_dut%0d", w), 32'(ok), 32'd1);
    chk_i($sformatf("busrq_rel_dut%0d", w), 32'(get_busrq(w)), 32'd0);
    chk_i($sformatf("busy_rel_dut%0d", w), 32'(get_busy(w)), 32'd1);
    busak0 = 1'b0;
    busak1 = 1'b0;
    @(negedge clk_sys);
    chk_i($sformatf("busy_idle_dut%0d", w), 32'(get_busy(w)), 32'd0);
  endtask

  // Monitor: compare dir_out at each dir_set rise, check stability and pulse length
  initial begin
    bit           act[2];
    int           len[2];
    logic [211:0] held[2];
    logic         ds;
    logic [211:0] dv;
    logic [211:0] e;
    act[0] = 1'b0;
    act[1] = 1'b0;
    len[0] = 0;
    len[1] = 0;
    forever begin
      @(negedge clk_sys);
      for (int i = 0; i < 2; i++) begin
        ds = (i == 0) ? dset0 : dset1;
        dv = (i == 0) ? dout0 : dout1;
        if (reset) begin
          act[i] = 1'b0;
        end else if (ds && !act[i]) begin
          act[i]  = 1'b1;
          len[i]  = 1;
          held[i] = dv;
          if (((i == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dir_set_dut%0d: dir_set=1 expected 0", i);
          end else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk_v($sformatf("dir_out_dut%0d", i), dv, e);
          end
        end else if (ds && act[i]) begin
          len[i]++;
          chk_v($sformatf("dir_out_stable_dut%0d", i), dv, held[i]);
        end else if (!ds && act[i]) begin
          act[i] = 1'b0;
          chk_i($sformatf("dir_set_len_dut%0d", i), 32'(len[i]), 32'd4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [211:0] e;
    int           cnt;
    bit           ok;

    reset = 1'b1;
    load_start = 1'b0;
    load_wr = 1'b0;
    load_data = 8'h00;
    execute_addr = 16'h0000;
    exec0 = 1'b0;
    exec1 = 1'b0;
    busak0 = 1'b0;
    busak1 = 1'b0;
    for (int k = 0; k < 26; k++) dir_in[8*k +: 8] = 8'h80 + 8'(k);
    dir_in[211:208] = 4'h6;

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk_i("rst_busrq0", 32'(busrq0), 32'd0);
    chk_i("rst_dset0", 32'(dset0), 32'd0);
    chk_i("rst_busy0", 32'(busy0), 32'd0);
    chk_i("rst_err0", 32'(err0), 32'd0);
    chk_v("rst_dout0", dout0, 212'd0);
    chk_i("rst_busrq1", 32'(busrq1), 32'd0);
    chk_i("rst_dset1", 32'(dset1), 32'd0);
    chk_v("rst_dout1", dout1, 212'd0);
    reset = 1'b0;
    tick();

    // No image: PC from execute_addr (sampled at latch), SP from SP_ADDR
    execute_addr = 16'h1234;
    e = dir_in;
    e[79:64] = 16'h5200;
    e[63:48] = 16'h4200;
    exp_q0.push_back(im_fix(e));
    do_exec(0, 16'h5200);

    // Reset during the second SET cycle
    execute_addr = 16'h6000;
    e = dir_in;
    e[79:64] = 16'h6000;
    e[63:48] = 16'h4200;
    exp_q0.push_back(im_fix(e));
    busak0 = 1'b1;
    exec0 = 1'b1;
    tick();
    exec0 = 1'b0;
    wait_dset(0, 1'b1, ok);
    chk_i("rst_test_dset_rise", 32'(ok), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk_sys);
    chk_i("midrst_dset0", 32'(dset0), 32'd0);
    chk_i("midrst_busrq0", 32'(busrq0), 32'd0);
    chk_v("midrst_dout0", dout0, 212'd0);
    chk_i("midrst_busy0", 32'(busy0), 32'd0);
    reset = 1'b0;
    busak0 = 1'b0;
    tick();

    // Full 27-byte image, PC/SP from image (dut1)
    for (int i = 0; i < 27; i++) img[i] = 8'h11 + 8'(i);
    load_img(27);
    @(negedge clk_sys);
    chk_i("full_img_err1", 32'(err1), 32'd0);
    for (int k = 0; k < 26; k++) e[8*k +: 8] = 8'h11 + 8'(k);
    e[211:208] = 4'hB;
    chk_v("full_img_pc_expect", 212'(e[79:64]), 212'(16'h1A19));
    exp_q1.push_back(im_fix(e));
    do_exec(1, 16'h7777);
    // Mask retained: a second execute reuses the same image
    exp_q1.push_back(im_fix(e));
    do_exec(1, 16'h7777);

    // Overflow: 28 bytes, the last is dropped and err set
    for (int i = 0; i < 28; i++) img[i] = 8'h30 + 8'(i);
    load_img(28);
    @(negedge clk_sys);
    chk_i("ovf_err1", 32'(err1), 32'd1);
    chk_i("ovf_err0", 32'(err0), 32'd1);
    for (int k = 0; k < 26; k++) e[8*k +: 8] = 8'h30 + 8'(k);
    e[211:208] = 4'hA;
    exp_q1.push_back(im_fix(e));
    do_exec(1, 16'h7777);
    chk_i("ovf_err_sticky", 32'(err1), 32'd1);
    load_img(0);
    @(negedge clk_sys);
    chk_i("ovf_err_cleared", 32'(err1), 32'd0);

    // Byte 26 = 0x0F: IM/IFF nibble
    for (int i = 0; i < 26; i++) img[i] = 8'h40 + 8'(i);
    img[26] = 8'h0F;
    load_img(27);
    for (int k = 0; k < 26; k++) e[8*k +: 8] = 8'h40 + 8'(k);
`ifdef REGSET_FORCE_IM1_EN
    e[211:208] = 4'b0001;
`else
    e[211:208] = 4'b1111;
`endif
    exp_q1.push_back(e);
    do_exec(1, 16'h7777);

    // Partial image: unloaded PC/SP bytes fall back to dir_in
    img[0] = 8'hE0;
    img[1] = 8'hE1;
    img[2] = 8'hE2;
    load_img(3);
    e = dir_in;
    e[23:0] = 24'hE2E1E0;
    exp_q1.push_back(im_fix(e));
    do_exec(1, 16'h7777);

    // Bus-acknowledge timeout on dut0
    busak0 = 1'b0;
    exec0 = 1'b1;
    tick();
    exec0 = 1'b0;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_sys);
      if (busrq0) cnt++;
      else if (cnt > 0) break;
    end
    chk_i("timeout_busrq_cycles", 32'(cnt), 32'd16);
    chk_i("timeout_err0", 32'(err0), 32'd1);
    chk_i("timeout_busy0", 32'(busy0), 32'd0);
    chk_i("timeout_err1_untouched", 32'(err1), 32'd0);

    repeat (5) tick();
    chk_i("queue0_drained", 32'(exp_q0.size()), 32'd0);
    chk_i("queue1_drained", 32'(exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
